// File: rtl/coffee_pkg.sv
// Shared definitions for the brew sequencer: drink codes, state encoding,
// valve bit positions and the recipe duration table.
package coffee_pkg;

  // Drink codes presented on c_type.
  localparam logic [2:0] CTypeNone   = 3'd0;
  localparam logic [2:0] CTypeCoffee = 3'd1;
  localparam logic [2:0] CTypeMilk   = 3'd2;
  localparam logic [2:0] CTypeCappu  = 3'd3;
  localparam logic [2:0] CTypeMocca  = 3'd4;

  // State encoding doubles as the stage display code.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWater  = 3'd1,
    StCoffee = 3'd2,
    StMilk   = 3'd3,
    StFoam   = 3'd4,
    StChoco  = 3'd5
  } state_e;

  // Valve bit positions.
  localparam int unsigned NumValves  = 5;
  localparam int unsigned ValveWater  = 0;
  localparam int unsigned ValveCoffee = 1;
  localparam int unsigned ValveMilk   = 2;
  localparam int unsigned ValveFoam   = 3;
  localparam int unsigned ValveChoco  = 4;

  function automatic logic ctype_valid(input logic [2:0] c);
    return (c >= CTypeCoffee) && (c <= CTypeMocca);
  endfunction

  // Stage duration in seconds for a drink; 0 means the stage is skipped.
  function automatic logic [3:0] recipe_dur(input logic [2:0] drink, input state_e st);
    logic [3:0] d;
    d = 4'd0;
    case (drink)
      CTypeCoffee: begin
        case (st)
          StWater:  d = 4'd3;
          StCoffee: d = 4'd4;
          default:  d = 4'd0;
        endcase
      end
      CTypeMilk: begin
        case (st)
          StWater, StCoffee, StMilk: d = 4'd3;
          default:                   d = 4'd0;
        endcase
      end
      CTypeCappu: begin
        case (st)
          StWater, StCoffee, StFoam: d = 4'd3;
          StMilk:                    d = 4'd2;
          default:                   d = 4'd0;
        endcase
      end
      CTypeMocca: begin
        case (st)
          StWater, StCoffee: d = 4'd3;
          StMilk, StChoco:   d = 4'd2;
          default:           d = 4'd0;
        endcase
      end
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // First stage after cur with a non-zero duration, or StIdle if none remain.
  function automatic state_e next_stage(input logic [2:0] drink, input state_e cur);
    state_e res;
    res = StIdle;
    // Walk downwards so the lowest qualifying stage is the one left in res.
    for (int s = 5; s >= 1; s--) begin
      if ((s > int'(cur)) && (recipe_dur(drink, state_e'(s[2:0])) != 4'd0)) begin
        res = state_e'(s[2:0]);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick prescaler.
// Ports: clk, reset_n (async active-low), clear (synchronous count clear),
//        tick (one-cycle strobe every TICK_DIV cycles).
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == CntMax);
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/brew_sequencer.sv
// Drink brewing sequencer: steps through water/coffee/milk/foam/choco stages
// with recipe-dependent durations, skipping zero-length stages.
// Ports: clk, reset_n (async active-low), start (pulse), c_type (drink code),
//        cancel (level) in; busy, valves (one-hot), stage (state code),
//        remaining (seconds left), done and aborted (one-cycle pulses) out.
module brew_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           c_type,
  input  logic                 cancel,
  output logic                 busy,
  output logic [NumValves-1:0] valves,
  output logic [2:0]           stage,
  output logic [3:0]           remaining,
  output logic                 done,
  output logic                 aborted
);

  state_e     state_q, state_d;
  logic [2:0] drink_q, drink_d;
  logic [3:0] remaining_q, remaining_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       tick;
  logic       tick_clear;
  state_e     nxt;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tick_clear),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      drink_q     <= CTypeNone;
      remaining_q <= 4'd0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drink_q     <= drink_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    drink_d     = drink_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    tick_clear  = 1'b0;
    nxt         = StIdle;

    if (state_q == StIdle) begin
      // Prescaler held at zero so the first stage starts with a full second.
      tick_clear  = 1'b1;
      remaining_d = 4'd0;
      if (start && !cancel && ctype_valid(c_type)) begin
        drink_d     = c_type;
        nxt         = next_stage(c_type, StIdle);
        state_d     = nxt;
        remaining_d = recipe_dur(c_type, nxt);
      end
    end else if (cancel) begin
      state_d     = StIdle;
      drink_d     = CTypeNone;
      remaining_d = 4'd0;
      aborted_d   = 1'b1;
      tick_clear  = 1'b1;
    end else if (tick) begin
      if (remaining_q > 4'd1) begin
        remaining_d = remaining_q - 4'd1;
      end else begin
        nxt        = next_stage(drink_q, state_q);
        state_d    = nxt;
        tick_clear = 1'b1;
        if (nxt == StIdle) begin
          drink_d     = CTypeNone;
          remaining_d = 4'd0;
          done_d      = 1'b1;
        end else begin
          remaining_d = recipe_dur(drink_q, nxt);
        end
      end
    end
  end

  // Outputs decoded from the state register so reset closes valves at once.
  always_comb begin
    valves = '0;
    case (state_q)
      StWater:  valves[ValveWater]  = 1'b1;
      StCoffee: valves[ValveCoffee] = 1'b1;
      StMilk:   valves[ValveMilk]   = 1'b1;
      StFoam:   valves[ValveFoam]   = 1'b1;
      StChoco:  valves[ValveChoco]  = 1'b1;
      default:  valves = '0;
    endcase
    busy      = (state_q != StIdle);
    stage     = state_q;
    remaining = remaining_q;
    done      = done_q;
    aborted   = aborted_q;
  end

endmodule

// File: tb/tb_brew_sequencer.sv
module tb_brew_sequencer;

  localparam int TD = 4;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] c_type;
  logic       cancel;
  logic       busy;
  logic [4:0] valves;
  logic [2:0] stage;
  logic [3:0] remaining;
  logic       done;
  logic       aborted;

  int total;
  int bad;

  brew_sequencer #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .c_type   (c_type),
    .cancel   (cancel),
    .busy     (busy),
    .valves   (valves),
    .stage    (stage),
    .remaining(remaining),
    .done     (done),
    .aborted  (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recipe seconds per drink (row) and stage 1..5 (column).
  int dur_tab [0:7][0:5];

  // Model: cycles left in the current stage, stage number, latched drink.
  int m_stage;
  int m_left;
  int m_drink;
  bit m_done;
  bit m_abort;

  function automatic int mdur(input int d, input int s);
    return dur_tab[d][s];
  endfunction

  function automatic int first_after(input int d, input int s);
    for (int k = s + 1; k <= 5; k++) begin
      if (mdur(d, k) != 0) return k;
    end
    return 0;
  endfunction

  initial begin
    for (int d = 0; d < 8; d++) for (int s = 0; s < 6; s++) dur_tab[d][s] = 0;
    dur_tab[1][1] = 3; dur_tab[1][2] = 4;
    dur_tab[2][1] = 3; dur_tab[2][2] = 3; dur_tab[2][3] = 3;
    dur_tab[3][1] = 3; dur_tab[3][2] = 3; dur_tab[3][3] = 2; dur_tab[3][4] = 3;
    dur_tab[4][1] = 3; dur_tab[4][2] = 3; dur_tab[4][3] = 2; dur_tab[4][5] = 2;
  end

  // Model advances on each rising edge from the inputs held across it.
  initial begin
    m_stage = 0; m_left = 0; m_drink = 0; m_done = 0; m_abort = 0;
    forever begin
      @(posedge clk);
      m_done  = 0;
      m_abort = 0;
      if (!reset_n) begin
        m_stage = 0; m_left = 0; m_drink = 0;
      end else if (m_stage == 0) begin
        if (start && !cancel && c_type >= 1 && c_type <= 4) begin
          m_drink = int'(c_type);
          m_stage = first_after(m_drink, 0);
          m_left  = mdur(m_drink, m_stage) * TD;
        end
      end else if (cancel) begin
        m_stage = 0; m_left = 0; m_abort = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_stage = first_after(m_drink, m_stage);
          if (m_stage == 0) m_done = 1;
          else m_left = mdur(m_drink, m_stage) * TD;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int e_rem;
    logic [4:0] e_valves;
    if (reset_n) begin
      e_rem    = (m_stage == 0) ? 0 : (m_left + TD - 1) / TD;
      e_valves = (m_stage == 0) ? 5'd0 : 5'(1 << (m_stage - 1));
      total++;
      if (busy !== (m_stage != 0) || valves !== e_valves || stage !== 3'(m_stage) ||
          remaining !== 4'(e_rem) || done !== m_done || aborted !== m_abort) begin
        bad++;
        $display("FAIL model t=%0t got busy=%b valves=%b stage=%0d rem=%0d done=%b ab=%b exp busy=%b valves=%b stage=%0d rem=%0d done=%b ab=%b",
                 $time, busy, valves, stage, remaining, done, aborted,
                 (m_stage != 0), e_valves, m_stage, e_rem, m_done, m_abort);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [2:0] t);
    @(negedge clk);
    start  = 1'b1;
    c_type = t;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs until the brew ends, tallying per-stage cycles; optionally injects
  // a second start pulse (with a different drink) at cycle inj_at.
  task automatic measure(input int inj_at, input logic [2:0] inj_type,
                         output int nbusy, output int n1, output int n2,
                         output int n3, output int n4, output int n5,
                         output int ndone, output int nab);
    bit seen;
    bit fin;
    int cnt [0:5];
    seen = 0; fin = 0; nbusy = 0; ndone = 0; nab = 0;
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (i == inj_at) begin start = 1'b1; c_type = inj_type; end
      else start = 1'b0;
      if (busy) begin nbusy++; seen = 1; end
      if (stage <= 3'd5) cnt[int'(stage)]++;
      if (done) ndone++;
      if (aborted) nab++;
      if (seen && !busy) fin = 1;
    end
    start = 1'b0;
    if (!fin) check("measure_timeout", 0, 1);
    n1 = cnt[1]; n2 = cnt[2]; n3 = cnt[3]; n4 = cnt[4]; n5 = cnt[5];
  endtask

  task automatic wait_stage(input int s);
    int i;
    for (i = 0; i < 400 && stage != 3'(s); i++) @(negedge clk);
    if (stage != 3'(s)) check("wait_stage_timeout", int'(stage), s);
  endtask

  int nb, s1, s2, s3, s4, s5, nd, na;

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; c_type = 3'd0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valves", int'(valves), 0);
    check("reset_stage", int'(stage), 0);
    check("reset_rem", int'(remaining), 0);
    check("reset_pulses", int'(done) + int'(aborted), 0);
    reset_n = 1'b1;

    // Coffee: first-cycle latency and full timing.
    pulse_start(3'd1);
    #1;
    check("lat_busy", int'(busy), 1);
    check("lat_valves", int'(valves), 1);
    check("lat_rem", int'(remaining), 3);
    c_type = 3'd4;  // must not disturb the running brew
    measure(-1, 3'd0, nb, s1, s2, s3, s4, s5, nd, na);
    check("coffee_busy", nb, 28);
    check("coffee_water", s1, 12);
    check("coffee_coffee", s2, 16);
    check("coffee_done", nd, 1);

    // Cappuccino.
    pulse_start(3'd3);
    measure(-1, 3'd0, nb, s1, s2, s3, s4, s5, nd, na);
    check("cappu_busy", nb, 44);
    check("cappu_milk", s3, 8);
    check("cappu_foam", s4, 12);
    check("cappu_choco", s5, 0);
    check("cappu_done", nd, 1);

    // Mocca: foam skipped.
    pulse_start(3'd4);
    measure(-1, 3'd0, nb, s1, s2, s3, s4, s5, nd, na);
    check("mocca_busy", nb, 40);
    check("mocca_foam", s4, 0);
    check("mocca_choco", s5, 8);
    check("mocca_done", nd, 1);

    // Cancel 5 cycles into coffee of coffee+milk.
    pulse_start(3'd2);
    wait_stage(2);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", int'(busy), 0);
    check("cancel_valves", int'(valves), 0);
    check("cancel_aborted", int'(aborted), 1);
    check("cancel_done", int'(done), 0);
    repeat (2) @(negedge clk);
    pulse_start(3'd2);
    measure(-1, 3'd0, nb, s1, s2, s3, s4, s5, nd, na);
    check("after_cancel_busy", nb, 36);
    check("after_cancel_done", nd, 1);

    // Ignored starts.
    pulse_start(3'd0);
    @(negedge clk);
    check("ign_c0", int'(busy), 0);
    pulse_start(3'd6);
    @(negedge clk);
    check("ign_c6", int'(busy), 0);
    @(negedge clk);
    cancel = 1'b1;
    pulse_start(3'd1);
    cancel = 1'b0;
    @(negedge clk);
    check("ign_cancel_start", int'(busy), 0);
    check("ign_cancel_ab", int'(aborted), 0);
    pulse_start(3'd1);
    measure(6, 3'd4, nb, s1, s2, s3, s4, s5, nd, na);
    check("busy_start_total", nb, 28);
    check("busy_start_milk", s3, 0);

    // Asynchronous reset mid-milk.
    pulse_start(3'd2);
    wait_stage(3);
    #2 reset_n = 1'b0;
    #1;
    check("areset_valves", int'(valves), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_pulses", int'(done) + int'(aborted), 0);
    @(negedge clk);
    check("areset_pulses_hold", int'(done) + int'(aborted), 0);
    reset_n = 1'b1;
    pulse_start(3'd1);
    measure(-1, 3'd0, nb, s1, s2, s3, s4, s5, nd, na);
    check("post_reset_busy", nb, 28);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second brew tick (minimum 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle pulse: payment accepted, begin brewing the selected drink.
REQ-005 c_type  input  3  drink code: 0 none, 1 coffee, 2 coffee+milk, 3 cappuccino, 4 mocca; 5-7 invalid.
REQ-006 cancel  input  1  level, debounced; aborts an active brew.
REQ-007 busy  output  1  high while any brew stage is active.
REQ-008 valves  output  5  one-hot stage drive: [0] water, [1] coffee, [2] milk, [3] foam, [4] choco.
REQ-009 stage  output  3  current state code for LED/display use.
REQ-010 remaining  output  4  seconds left in the current stage; 0 when idle.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 aborted  output  1  one-cycle pulse on cancel-induced termination.

Function
REQ-013 States: IDLE, WATER, COFFEE, MILK, FOAM, CHOCO; stage encodes them as 0-5 in that order.
REQ-014 Recipe durations in seconds (water/coffee/milk/foam/choco): coffee 3/4/0/0/0; coffee+milk 3/3/3/0/0; cappuccino 3/3/2/3/0; mocca 3/3/2/0/2.
REQ-015 Stages proceed in fixed order WATER, COFFEE, MILK, FOAM, CHOCO; stages with duration 0 are skipped with no idle cycle.
REQ-016 In IDLE, start=1 with valid c_type (1-4) latches c_type and enters WATER on the next edge; c_type changes after that edge have no effect on the running brew.
REQ-017 start with c_type 0 or 5-7 is ignored: state stays IDLE and no output changes.
REQ-018 start while busy is ignored.
REQ-019 On stage entry, remaining loads that stage's duration and the tick prescaler clears, so each stage lasts exactly duration x TICK_DIV cycles.
REQ-020 remaining decrements by 1 on each tick; the tick that would take it from 1 to 0 instead moves to the next non-zero stage, or ends the brew.
REQ-021 End of brew: state returns to IDLE, valves go to 0, remaining goes to 0, and done=1 for that one cycle.
REQ-022 valves equals the one-hot bit of the current stage; exactly one bit is high when busy, and all bits are 0 in IDLE.
REQ-023 busy=1 exactly when state is not IDLE.
REQ-024 cancel=1 in any non-IDLE state: the next edge forces IDLE, valves=0 and remaining=0, and aborted=1 for one cycle; done stays 0.
REQ-025 cancel in IDLE has no effect; cancel and start asserted in the same IDLE cycle: cancel wins and no brew starts.
REQ-026 cancel on the same cycle as the final tick: cancel wins, so aborted=1 and done=0.
REQ-027 Latency: start sampled at edge k gives busy=1, valves=00001 and remaining=3 after edge k.
REQ-028 The prescaler counter width is clog2(TICK_DIV); the tick is a one-cycle strobe when the count reaches TICK_DIV-1, after which the count wraps to 0.

Reset
REQ-029 reset_n=0 asynchronously forces IDLE, with valves=0, busy=0, stage=0, remaining=0, done=0, aborted=0, prescaler=0 and the latched drink=0.
REQ-030 Reset asserted mid-brew closes all valves immediately, without waiting for a clock edge; neither done nor aborted pulses.
REQ-031 After reset_n deasserts, the block is idle and accepts start from the first rising edge.

Structure
REQ-032 A shared package coffee_pkg holds: the c_type code constants, the state encoding, the recipe duration table, and the valve bit indices.
REQ-033 One sub-module, tick_gen, holds the prescaler with a synchronous clear input and a tick output.
REQ-034 No other hierarchy is used; the recipe lookup is combinational from the latched drink and the current state.

Verification (TICK_DIV=4)
REQ-035 Reset, then start with c_type=1 -> busy for 28 cycles: water 12 cycles, then coffee 16 cycles; done pulses once; remaining counts 3,2,1 then 4,3,2,1.
REQ-036 start with c_type=3 -> stage sequence 1,2,3,4 with 12/12/8/12 cycles; valves 00001, 00010, 00100, 01000; CHOCO is never entered.
REQ-037 start with c_type=4 -> stages 1,2,3,5; FOAM is skipped with no gap cycle; total 40 cycles; then done.
REQ-038 cancel raised 5 cycles into COFFEE of a c_type=2 brew -> next edge gives IDLE, valves=0, aborted pulse and no done; a later start runs normally.
REQ-039 start with c_type=0 or 6, start pulsed during a brew, and start together with cancel -> state never changes because of these starts.
REQ-040 reset_n pulsed low mid-MILK with no clock edge -> valves=0 within the same cycle; done and aborted stay 0.
